// File: rtl/and_nway_bist_if.sv
// Signal bundle between an and_nway_bist engine and whatever controls it and
// hosts the gate under test.
interface and_nway_bist_if #(
    parameter int unsigned NB_IN = 8
);
    logic             start;
    logic [1:0]       func_sel;
    logic [NB_IN-1:0] vec_out;
    logic             dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [NB_IN:0]   err_count;
    logic [NB_IN-1:0] first_fail_vec;
    logic             first_fail_vld;

    modport master (
        output start, func_sel, dut_out,
        input  vec_out, busy, done, pass, err_count, first_fail_vec, first_fail_vld
    );

    modport slave (
        input  start, func_sel, dut_out,
        output vec_out, busy, done, pass, err_count, first_fail_vec, first_fail_vld
    );
endinterface

// File: rtl/and_nway_bist.sv
// Exhaustive stimulus/response engine for N-input reduction gates: sweeps every
// input vector, waits a settle window, and checks dut_out against the chosen function.
module and_nway_bist #(
    parameter int unsigned NB_IN  = 8,
    parameter int unsigned SETTLE = 1
) (
    input logic            clk,
    input logic            reset,
    and_nway_bist_if.slave bus
);
    localparam int unsigned   CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, SETTLE_WAIT, SAMPLE, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       fn;
    logic [NB_IN-1:0] vec;
    logic             busy;
    logic             done;
    logic             pass;
    logic [NB_IN:0]   err;
    logic [NB_IN-1:0] ffv;
    logic             ffvld;
    logic             exp_bit;
    logic             mismatch;

    // x/z on dut_out must register as a failure, hence the case inequality.
    always_comb begin
        exp_bit = 1'b0;
        case (fn)
            2'b00:   exp_bit = &vec;
            2'b01:   exp_bit = |vec;
            2'b10:   exp_bit = ^vec;
            default: exp_bit = ~&vec;
        endcase
        mismatch = (bus.dut_out !== exp_bit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            fn    <= '0;
            vec   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
            err   <= '0;
            ffv   <= '0;
            ffvld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        fn    <= bus.func_sel;
                        err   <= '0;
                        ffv   <= '0;
                        ffvld <= 1'b0;
                        vec   <= '0;
                        pass  <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= RELOAD;
                        state <= SETTLE_WAIT;
                    end
                end
                SETTLE_WAIT: begin
                    if (cnt == '0) state <= SAMPLE;
                    else           cnt   <= cnt - 1'b1;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err <= err + 1'b1;
                        if (!ffvld) begin
                            ffv   <= vec;
                            ffvld <= 1'b1;
                        end
                    end
                    // pass has to include the compare being made on this edge.
                    if (vec == '1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err == '0) && !mismatch;
                        state <= DONE;
                    end else begin
                        vec   <= vec + 1'b1;
                        cnt   <= RELOAD;
                        state <= SETTLE_WAIT;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.vec_out        = vec;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = pass;
    assign bus.err_count      = err;
    assign bus.first_fail_vec = ffv;
    assign bus.first_fail_vld = ffvld;
endmodule

// File: tb/tb_and_nway_bist.sv
// Drives two engines (SETTLE=1 and SETTLE=3) against a table-defined gate with
// matching input latency and checks every sweep against an exhaustive reference.
module tb_and_nway_bist;
    localparam int unsigned NB = 8;
    localparam int unsigned NV = 1 << NB;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [1:0] func_sel;
    always #5 clk = ~clk;

    and_nway_bist_if #(.NB_IN(NB)) bus_a ();
    and_nway_bist_if #(.NB_IN(NB)) bus_b ();

    and_nway_bist #(.NB_IN(NB), .SETTLE(1)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
    and_nway_bist #(.NB_IN(NB), .SETTLE(3)) u_b (.clk(clk), .reset(reset), .bus(bus_b));

    // Gate under test: truth table seen through a SETTLE-deep input pipeline, so
    // sampling one cycle early reads the previous vector's answer.
    logic [NV-1:0] gate_vec;
    logic [NB-1:0] dl_a;
    logic [NB-1:0] dl_b [3];
    always @(posedge clk) begin
        dl_a    <= bus_a.vec_out;
        dl_b[0] <= bus_b.vec_out;
        dl_b[1] <= dl_b[0];
        dl_b[2] <= dl_b[1];
    end

    assign bus_a.start    = start;
    assign bus_b.start    = start;
    assign bus_a.func_sel = func_sel;
    assign bus_b.func_sel = func_sel;
    assign bus_a.dut_out  = gate_vec[dl_a];
    assign bus_b.dut_out  = gate_vec[dl_b[2]];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned exp_err, exp_ffv;
    bit          exp_vld, exp_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_fn(input logic [1:0] fs, input int unsigned v);
        int ones;
        ones = $countones(v);
        case (fs)
            2'b00:   return ones == NB;
            2'b01:   return ones != 0;
            2'b10:   return ones[0];
            default: return ones != NB;
        endcase
    endfunction

    task automatic set_gate(input int unsigned mode);
        for (int unsigned v = 0; v < NV; v++) begin
            case (mode)
                0:       gate_vec[v] = ref_fn(2'b00, v);
                1:       gate_vec[v] = 1'b0;
                2:       gate_vec[v] = ref_fn(2'b00, v) ^ ($urandom_range(0, 40) == 0);
                3:       gate_vec[v] = 1'($urandom);
                4:       gate_vec[v] = 1'b1;
                default: gate_vec[v] = ref_fn(2'b10, v);
            endcase
        end
    endtask

    task automatic compute_model(input logic [1:0] fs);
        exp_err = 0;
        exp_vld = 1'b0;
        exp_ffv = 0;
        for (int unsigned v = 0; v < NV; v++) begin
            if (gate_vec[v] != ref_fn(fs, v)) begin
                exp_err++;
                if (!exp_vld) begin
                    exp_vld = 1'b1;
                    exp_ffv = v;
                end
            end
        end
        exp_pass = (exp_err == 0);
    endtask

    task automatic chk_rst(input string nm, input logic [NB-1:0] vec, input logic busy,
                           input logic done, input logic pass, input logic [NB:0] err,
                           input logic [NB-1:0] ffv, input logic ffvld);
        chk({nm, "_rst_vec"}, vec, 0);
        chk({nm, "_rst_busy"}, busy, 0);
        chk({nm, "_rst_done"}, done, 0);
        chk({nm, "_rst_pass"}, pass, 0);
        chk({nm, "_rst_err"}, err, 0);
        chk({nm, "_rst_ffv"}, ffv, 0);
        chk({nm, "_rst_ffvld"}, ffvld, 0);
    endtask

    task automatic chk_res(input string nm, input logic [NB-1:0] vec, input logic busy,
                           input logic pass, input logic [NB:0] err,
                           input logic [NB-1:0] ffv, input logic ffvld);
        chk({nm, "_vec"}, vec, NV - 1);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_pass"}, pass, exp_pass);
        chk({nm, "_err"}, err, exp_err);
        chk({nm, "_ffvld"}, ffvld, exp_vld);
        if (exp_vld) chk({nm, "_ffv"}, ffv, exp_ffv);
    endtask

    task automatic sweep(input logic [1:0] fs, input bit poke);
        int unsigned n, cnt_a, cnt_b;
        bit seen_a, seen_b;
        compute_model(fs);
        @(negedge clk);
        start    = 1'b1;
        func_sel = fs;
        @(negedge clk);
        start    = 1'b0;
        func_sel = ~fs;
        chk("first_busy_a", bus_a.busy, 1);
        chk("first_busy_b", bus_b.busy, 1);
        chk("start_clr_err_a", bus_a.err_count, 0);
        chk("start_clr_vld_b", bus_b.first_fail_vld, 0);
        chk("start_clr_pass_a", bus_a.pass, 0);
        n = 0; cnt_a = 0; cnt_b = 0; seen_a = 1'b0; seen_b = 1'b0;
        while (!(seen_a && seen_b) && n < 8 * NV) begin
            start = poke && (n == 50 || n == 300);
            if (!seen_a) begin
                if (bus_a.busy) cnt_a++;
                if (bus_a.done) begin
                    seen_a = 1'b1;
                    chk_res("a", bus_a.vec_out, bus_a.busy, bus_a.pass, bus_a.err_count,
                            bus_a.first_fail_vec, bus_a.first_fail_vld);
                end
            end
            if (!seen_b) begin
                if (bus_b.busy) cnt_b++;
                if (bus_b.done) begin
                    seen_b = 1'b1;
                    chk_res("b", bus_b.vec_out, bus_b.busy, bus_b.pass, bus_b.err_count,
                            bus_b.first_fail_vec, bus_b.first_fail_vld);
                end
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("done_seen_a", seen_a, 1);
        chk("done_seen_b", seen_b, 1);
        chk("len_a", cnt_a, NV * 2);
        chk("len_b", cnt_b, NV * 4);
        chk("done_pulse_a", bus_a.done, 0);
        chk("done_pulse_b", bus_b.done, 0);
        chk("hold_err_a", bus_a.err_count, exp_err);
        chk("hold_pass_a", bus_a.pass, exp_pass);
        chk("hold_vec_a", bus_a.vec_out, NV - 1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        func_sel = 2'b00;
        set_gate(0);
        repeat (3) @(negedge clk);
        chk_rst("a", bus_a.vec_out, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count,
                bus_a.first_fail_vec, bus_a.first_fail_vld);
        chk_rst("b", bus_b.vec_out, bus_b.busy, bus_b.done, bus_b.pass, bus_b.err_count,
                bus_b.first_fail_vec, bus_b.first_fail_vld);
        reset = 1'b0;

        sweep(2'b00, 1'b0);   // AND gate checked as AND: clean
        sweep(2'b01, 1'b0);   // as OR: 254 errors, first 0x01
        sweep(2'b10, 1'b1);   // as XOR: 129 errors, starts while busy ignored
        set_gate(1);
        sweep(2'b00, 1'b0);   // tied 0: single error at all-ones

        // Abort at cycle 100 of a sweep.
        set_gate(0);
        @(negedge clk);
        start = 1'b1;
        func_sel = 2'b01;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_rst("abort_a", bus_a.vec_out, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count,
                bus_a.first_fail_vec, bus_a.first_fail_vld);
        chk_rst("abort_b", bus_b.vec_out, bus_b.busy, bus_b.done, bus_b.pass, bus_b.err_count,
                bus_b.first_fail_vec, bus_b.first_fail_vld);
        reset = 1'b0;
        sweep(2'b00, 1'b0);

        for (int i = 0; i < 5; i++) begin
            set_gate($urandom_range(0, 5));
            sweep(2'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
